// File: rtl/rom_read_arbiter.sv
// Round-robin read arbiter sharing one single-port ROM between two requesters.
// Each requester gets a registered response slot with valid/ready backpressure.
module rom_read_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 36
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  input  logic              rsp0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  input  logic              rsp1_ready,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q
);

  logic              elig0_s;
  logic              elig1_s;
  logic              gnt_any_s;
  logic              gnt_sel_s;
  logic              pend_r;
  logic              pend_sel_r;
  logic              last_gnt_r;
  logic [1:0]        rsp_valid_r;
  logic [DATA_W-1:0] rsp_data0_r;
  logic [DATA_W-1:0] rsp_data1_r;

  // Eligibility and grant selection; a port with a read in flight or a stalled response sits out
  always_comb begin
    elig0_s   = req0_valid && !(pend_r && (pend_sel_r == 1'b0)) && (!rsp_valid_r[0] || rsp0_ready);
    elig1_s   = req1_valid && !(pend_r && (pend_sel_r == 1'b1)) && (!rsp_valid_r[1] || rsp1_ready);
    gnt_any_s = elig0_s || elig1_s;
    if (elig0_s && elig1_s) begin
      gnt_sel_s = ~last_gnt_r;
    end else if (elig1_s) begin
      gnt_sel_s = 1'b1;
    end else begin
      gnt_sel_s = 1'b0;
    end
  end

  // Grant-driven ROM and ready outputs
  always_comb begin
    rom_ce     = gnt_any_s;
    req0_ready = gnt_any_s && (gnt_sel_s == 1'b0);
    req1_ready = gnt_any_s && (gnt_sel_s == 1'b1);
    if (!gnt_any_s) begin
      rom_addr = {ADDR_W{1'b0}};
    end else if (gnt_sel_s) begin
      rom_addr = req1_addr;
    end else begin
      rom_addr = req0_addr;
    end
  end

  // In-flight tracking and round-robin history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r     <= 1'b0;
      pend_sel_r <= 1'b0;
      last_gnt_r <= 1'b1;
    end else begin
      pend_r <= gnt_any_s;
      if (gnt_any_s) begin
        pend_sel_r <= gnt_sel_s;
        last_gnt_r <= gnt_sel_s;
      end else begin
        pend_sel_r <= pend_sel_r;
        last_gnt_r <= last_gnt_r;
      end
    end
  end

  // Response slots: drain on handshake, load ROM data the cycle after a grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r <= 2'b00;
      rsp_data0_r <= {DATA_W{1'b0}};
      rsp_data1_r <= {DATA_W{1'b0}};
    end else begin
      if (rsp_valid_r[0] && rsp0_ready) begin
        rsp_valid_r[0] <= 1'b0;
      end
      if (rsp_valid_r[1] && rsp1_ready) begin
        rsp_valid_r[1] <= 1'b0;
      end
      // Same-port load and drain cannot overlap, so the load needs no priority care
      if (pend_r) begin
        if (pend_sel_r) begin
          rsp_valid_r[1] <= 1'b1;
          rsp_data1_r    <= rom_q;
        end else begin
          rsp_valid_r[0] <= 1'b1;
          rsp_data0_r    <= rom_q;
        end
      end
    end
  end

  assign rsp0_valid = rsp_valid_r[0];
  assign rsp1_valid = rsp_valid_r[1];
  assign rsp0_data  = rsp_data0_r;
  assign rsp1_data  = rsp_data1_r;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Self-checking bench for rom_read_arbiter: behavioural ROM plus a transaction-level
// model of grants and response slots, compared every cycle.
module tb_rom_read_arbiter;
  localparam int AW = 13;
  localparam int DW = 36;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic [AW-1:0] req0_addr = '0, req1_addr = '0;
  logic          rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid, rom_ce;
  logic [DW-1:0] rsp0_data, rsp1_data, rom_q;
  logic [AW-1:0] rom_addr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rom_read_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_ready(rsp0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_ready(rsp1_ready),
    .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_q(rom_q)
  );

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return {a, ~a, a[9:0]};
  endfunction

  // ROM macro: data valid the cycle after ce, garbage otherwise
  always @(posedge clk) rom_q <= rom_ce ? rom_word(rom_addr) : 36'({$urandom(), $urandom()});

  // Transaction-level model state
  int            m_inflight;
  int            m_last;
  int            m_grant;
  logic [AW-1:0] m_in_addr;
  bit            m_full [2];
  logic [DW-1:0] m_data [2];
  logic [89:0]   exp_vec, obs_vec;

  task automatic model_reset();
    m_inflight = -1; m_last = 1; m_grant = -1;
    m_full[0] = 1'b0; m_full[1] = 1'b0; m_data[0] = '0; m_data[1] = '0;
  endtask

  task automatic drive(input bit v0, input logic [AW-1:0] a0, input bit r0,
                       input bit v1, input logic [AW-1:0] a1, input bit r1);
    req0_valid = v0; req0_addr = a0; rsp0_ready = r0;
    req1_valid = v1; req1_addr = a1; rsp1_ready = r1;
  endtask

  // Decide who should be granted now and what every output should read
  task automatic model_eval();
    bit e [2];
    logic [AW-1:0] ea;
    e[0] = req0_valid && m_inflight != 0 && (!m_full[0] || rsp0_ready);
    e[1] = req1_valid && m_inflight != 1 && (!m_full[1] || rsp1_ready);
    if (e[0] && e[1]) m_grant = 1 - m_last;
    else if (e[0])    m_grant = 0;
    else if (e[1])    m_grant = 1;
    else              m_grant = -1;
    ea = (m_grant == 0) ? req0_addr : (m_grant == 1) ? req1_addr : 13'd0;
    exp_vec = {(m_grant >= 0), ea, (m_grant == 0), (m_grant == 1), m_full[0], m_full[1],
               m_full[0] ? m_data[0] : 36'd0, m_full[1] ? m_data[1] : 36'd0};
    obs_vec = {rom_ce, rom_addr, req0_ready, req1_ready, rsp0_valid, rsp1_valid,
               rsp0_valid ? rsp0_data : 36'd0, rsp1_valid ? rsp1_data : 36'd0};
  endtask

  task automatic model_advance();
    if (m_full[0] && rsp0_ready) m_full[0] = 1'b0;
    if (m_full[1] && rsp1_ready) m_full[1] = 1'b0;
    if (m_inflight >= 0) begin
      m_full[m_inflight] = 1'b1;
      m_data[m_inflight] = rom_word(m_in_addr);
    end
    m_inflight = m_grant;
    if (m_grant >= 0) begin
      m_in_addr = (m_grant == 0) ? req0_addr : req1_addr;
      m_last = m_grant;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    model_reset();
    drive(1'b0, 13'd0, 1'b0, 1'b0, 13'd0, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if ({rom_ce, rom_addr, req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_data, rsp1_data} !== 90'd0) begin
      n_fail++;
      $display("FAIL reset_state: got ce=%b addr=%h rdy=%b%b rv=%b%b d0=%h d1=%h required all zero",
               rom_ce, rom_addr, req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_data, rsp1_data);
    end
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_single();
    for (int c = 1; c <= 4; c++) begin
      drive(c == 1, 13'h0005, 1'b1, 1'b0, 13'd0, 1'b1);
      #4; model_eval();
      n_tests++;
      if (obs_vec !== exp_vec) begin
        n_fail++; $display("FAIL single c%0d: got %h required %h", c, obs_vec, exp_vec);
      end
      if (c == 1) begin
        n_tests++;
        if (!(rom_ce === 1'b1 && rom_addr === 13'h0005 && req0_ready === 1'b1)) begin
          n_fail++; $display("FAIL single_grant: got ce=%b addr=%h rdy0=%b required 1 0005 1", rom_ce, rom_addr, req0_ready);
        end
      end
      if (c == 3) begin
        n_tests++;
        if (!(rsp0_valid === 1'b1 && rsp0_data === rom_word(13'h0005) && rsp1_valid === 1'b0)) begin
          n_fail++; $display("FAIL single_rsp: got v0=%b d0=%h v1=%b required 1 %h 0", rsp0_valid, rsp0_data, rsp1_valid, rom_word(13'h0005));
        end
      end
      model_advance(); next_cycle();
    end
  endtask

  task automatic test_fairness();
    for (int c = 0; c < 12; c++) begin
      drive(1'b1, 13'h0010, 1'b1, 1'b1, 13'h1FFF, 1'b1);
      #4; model_eval();
      n_tests++;
      if (obs_vec !== exp_vec) begin
        n_fail++; $display("FAIL fairness c%0d: got %h required %h", c, obs_vec, exp_vec);
      end
      n_tests++;
      if (!(rom_ce === 1'b1 && (req0_ready ^ req1_ready) === 1'b1)) begin
        n_fail++; $display("FAIL fairness_busy c%0d: got ce=%b rdy=%b%b required one grant", c, rom_ce, req0_ready, req1_ready);
      end
      model_advance(); next_cycle();
    end
  endtask

  task automatic test_backpressure();
    for (int c = 0; c < 16; c++) begin
      drive(1'b1, 13'(c * 7), c >= 11, 1'b1, 13'(13'h0100 + c), 1'b1);
      #4; model_eval();
      n_tests++;
      if (obs_vec !== exp_vec) begin
        n_fail++; $display("FAIL backpressure c%0d: got %h required %h", c, obs_vec, exp_vec);
      end
      if (c >= 4 && c < 11) begin
        n_tests++;
        if (!(rsp0_valid === 1'b1 && req0_ready === 1'b0)) begin
          n_fail++; $display("FAIL bp_hold c%0d: got v0=%b rdy0=%b required 1 0", c, rsp0_valid, req0_ready);
        end
      end
      model_advance(); next_cycle();
    end
  endtask

  task automatic test_idle();
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 13'($urandom), 1'b1, 1'b0, 13'($urandom), 1'b1);
      #4; model_eval();
      n_tests++;
      if (obs_vec !== exp_vec) begin
        n_fail++; $display("FAIL idle c%0d: got %h required %h", c, obs_vec, exp_vec);
      end
      if (c >= 3) begin
        n_tests++;
        if ({rom_ce, rom_addr, rsp0_valid, rsp1_valid} !== 16'd0) begin
          n_fail++; $display("FAIL idle_quiet c%0d: got ce=%b addr=%h rv=%b%b required zero", c, rom_ce, rom_addr, rsp0_valid, rsp1_valid);
        end
      end
      model_advance(); next_cycle();
    end
  endtask

  task automatic test_reset_mid();
    // Park a response on port 1, then issue a port 0 read and reset while it is in flight
    for (int c = 0; c < 3; c++) begin
      drive(c == 2, 13'h0AAA, 1'b1, c == 0, 13'h0555, 1'b0);
      #4; model_eval();
      n_tests++;
      if (obs_vec !== exp_vec) begin
        n_fail++; $display("FAIL reset_mid_pre c%0d: got %h required %h", c, obs_vec, exp_vec);
      end
      model_advance(); next_cycle();
    end
    drive(1'b0, 13'd0, 1'b0, 1'b0, 13'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({rsp0_valid, rsp1_valid, rom_ce, req0_ready, req1_ready} !== 5'd0) begin
      n_fail++; $display("FAIL reset_mid_async: got rv=%b%b ce=%b rdy=%b%b required zero", rsp0_valid, rsp1_valid, rom_ce, req0_ready, req1_ready);
    end
    model_reset();
    next_cycle();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      drive(c == 3, 13'h0001, 1'b1, c == 3, 13'h0002, 1'b1);
      #4; model_eval();
      n_tests++;
      if (obs_vec !== exp_vec) begin
        n_fail++; $display("FAIL reset_mid_post c%0d: got %h required %h", c, obs_vec, exp_vec);
      end
      if (c == 3) begin
        n_tests++;
        if (!(req0_ready === 1'b1 && req1_ready === 1'b0)) begin
          n_fail++; $display("FAIL reset_first_grant: got rdy=%b%b required 10", req0_ready, req1_ready);
        end
      end
      model_advance(); next_cycle();
    end
  endtask

  task automatic test_boundary();
    int n_acc = 0;
    int n_rsp = 0;
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, 13'd0, 1'b1, n_acc < 2, (n_acc == 0) ? 13'h0000 : 13'h1FFF, 1'b1);
      #4; model_eval();
      n_tests++;
      if (obs_vec !== exp_vec) begin
        n_fail++; $display("FAIL boundary c%0d: got %h required %h", c, obs_vec, exp_vec);
      end
      if (rsp1_valid === 1'b1) begin
        n_tests++;
        if (rsp1_data !== rom_word((n_rsp == 0) ? 13'h0000 : 13'h1FFF)) begin
          n_fail++; $display("FAIL boundary_rsp%0d: got %h required %h", n_rsp, rsp1_data, rom_word((n_rsp == 0) ? 13'h0000 : 13'h1FFF));
        end
        n_rsp++;
      end
      if (m_grant == 1) n_acc++;
      model_advance(); next_cycle();
    end
    n_tests++;
    if (n_rsp != 2) begin
      n_fail++; $display("FAIL boundary_count: got %0d responses required 2", n_rsp);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 3) != 0, 13'($urandom), $urandom_range(0, 2) != 0,
            $urandom_range(0, 3) != 0, 13'($urandom), $urandom_range(0, 2) != 0);
      #4; model_eval();
      n_tests++;
      if (obs_vec !== exp_vec) begin
        n_fail++; $display("FAIL random c%0d: got %h required %h", c, obs_vec, exp_vec);
      end
      model_advance(); next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_idle();
    test_reset_mid();
    test_boundary();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
